vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates 640x480@60 VGA raster timing from the 50 MHz system clock.
- Sits directly upstream of the picture/animation stage: drives hsync/vsync, the display-enable and the current pixel coordinates that the pattern logic turns into r/g/b.
- Also provides a pixel-clock enable and frame/line start pulses, so downstream stages run on sclk with no derived clocks.

Parameters:
- DIV, 2: sclk cycles per pixel (pixel enable period); legal values 1..8.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: active level of hsync/vsync (0 = active-low).
- CNT_W, 11: width of the internal counters and the coordinate outputs.

Ports:
- sclk  in  1  system clock, 50 MHz.
- srst  in  1  reset; asynchronous, active-low.
- pix_en  out  1  one-sclk pulse marking each pixel slot.
- hsync  out  1  horizontal sync, polarity set by SYNC_POL.
- vsync  out  1  vertical sync, polarity set by SYNC_POL.
- de  out  1  high while (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- px_x  out  CNT_W  column; equals h_cnt when de, else 0.
- px_y  out  CNT_W  row; equals v_cnt when de, else 0.
- line_start  out  1  one pix_en-qualified cycle at h_cnt==0.
- frame_start  out  1  one pix_en-qualified cycle at h_cnt==0 and v_cnt==0.

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Divider:
  - div_cnt runs 0..DIV-1 and wraps.
  - pix_en = (div_cnt == DIV-1), registered.
  - With DIV=1, pix_en is constantly 1 after reset.
- Horizontal counter: h_cnt advances only on pix_en cycles; at H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt advances on the same pix_en cycle in which h_cnt wraps; at V_TOTAL-1 it wraps to 0.
- Per-axis phase state machine, per counter: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Transitions occur when the counter reaches H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC and wrap respectively (vertical uses the V equivalents).
  - hsync/vsync are asserted exactly while the respective phase is SYNC.
- Output timing:
  - All outputs are registered and decoded from the next-state counter values.
  - Outputs therefore describe the counter values held in the same cycle: zero extra latency relative to the counters.
  - Every output is stable for the whole DIV-cycle pixel slot.
  - line_start and frame_start are high only in the pix_en cycle of their slot.
- Reset:
  - Applies asynchronously: div_cnt=0, h_cnt=0, v_cnt=0, both phases=ACTIVE, pix_en=0, hsync=vsync=~SYNC_POL (inactive), de=0, px_x=px_y=0, line_start=frame_start=0.
  - First pix_en comes DIV sclk cycles after reset release. On that cycle de=1, px_x=0, px_y=0, line_start=1, frame_start=1.
- Reset mid-frame: all state returns to the reset values immediately. No partial sync pulse may persist after srst falls.
- Wrap coincidence: when h_cnt and v_cnt wrap on the same pix_en, the next slot is (0,0) with frame_start=1. vsync deasserts, or asserts, exactly at the line boundary.
- Widths: counters are unsigned CNT_W. Elaboration fails if H_TOTAL or V_TOTAL is >= 2**CNT_W.

Decomposition:
- Package vga_pkg:
  - 640x480@60 timing constants and derived H_TOTAL/V_TOTAL.
  - Phase encoding typedef (ACTIVE, FRONT, SYNC, BACK).
  - Constant-function counter width helper.
- Sub-module vga_axis_cnt:
  - Generic counter plus phase FSM with ports en, cnt, wrap, phase, sync.
  - Instantiated twice: horizontal with en=pix_en; vertical with en=pix_en & h_wrap.

Test Plan:
- Reset hold then release at t=30 ns -> during reset hsync=vsync=1, de=0. First pix_en 2 sclk after release, with de=1, px_x=0, px_y=0, frame_start=1.
- Free run one line -> hsync period 1600 sclk; hsync low 192 sclk starting 1312 sclk after line_start; de high 1280 sclk per line.
- Free run two frames -> frame_start spacing 840000 sclk; vsync low 3200 sclk starting at v_cnt=490; 307200 de-qualified pix_en cycles per frame.
- Coordinate check -> at de, px_x runs 0..639 incrementing once per pix_en; px_y goes 479 -> 0 after the blanking interval; px_x=px_y=0 whenever de=0.
- Assert srst during the vsync pulse -> vsync returns to 1 asynchronously the same cycle; after release the sequence restarts at (0,0) with frame_start.
- Re-elaborate with DIV=1, SYNC_POL=1 -> pix_en stuck at 1; hsync high-active for 96 sclk, period 800 sclk.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing constants (in pixels / lines) and totals.
//   - phase_t: per-axis raster phase encoding.
//   - cnt_w(): width needed to hold the values 0..n-1, minimum 1 bit.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one raster axis (horizontal or vertical).
//   A 0..TOTAL-1 counter that advances on 'en', plus the phase FSM
//   ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE that tracks it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the counter this cycle
//   cnt        : registered count
//   cnt_nxt    : value cnt takes at the next edge (for registered decodes upstream)
//   wrap       : en while cnt is at TOTAL-1 (combinational)
//   phase      : registered phase, always consistent with cnt
//   sync       : registered sync output, level POL while phase is SYNC
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int CNT_W = 11,
    parameter int ACT   = 640,
    parameter int FP    = 16,
    parameter int SYN   = 96,
    parameter int BP    = 48,
    parameter bit POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap,
    output phase_t           phase,
    output logic             sync
);

    localparam int TOTAL = ACT + FP + SYN + BP;

    if (TOTAL >= 2**CNT_W) begin : g_width_chk
        $error("vga_axis_cnt: TOTAL=%0d does not fit in CNT_W=%0d", TOTAL, CNT_W);
    end

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_START = CNT_W'(ACT);
    localparam logic [CNT_W-1:0] SY_START = CNT_W'(ACT + FP);
    localparam logic [CNT_W-1:0] BP_START = CNT_W'(ACT + FP + SYN);

    phase_t phase_nxt;

    assign wrap = en && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (wrap)
            cnt_nxt = '0;
        else if (en)
            cnt_nxt = cnt + 1'b1;
    end

    // Phase follows the next count so the registered phase lines up with cnt.
    // Later boundaries are tested first so a zero-width porch skips cleanly.
    always_comb begin
        phase_nxt = phase;
        if (en) begin
            if (cnt_nxt == BP_START)
                phase_nxt = PH_BACK;
            else if (cnt_nxt == SY_START)
                phase_nxt = PH_SYNC;
            else if (cnt_nxt == FP_START)
                phase_nxt = PH_FRONT;
            else if (cnt_nxt == '0)
                phase_nxt = PH_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= PH_ACTIVE;
            sync  <= ~POL;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            sync  <= (phase_nxt == PH_SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator running on the system clock.
//   A divider produces a one-cycle pixel enable every DIV sclk cycles; the
//   horizontal axis advances on it and the vertical axis on the horizontal wrap.
// Ports:
//   sclk, srst  : system clock, asynchronous active-low reset
//   pix_en      : one-sclk pulse in the last cycle of each pixel slot
//   hsync/vsync : sync outputs, active level SYNC_POL
//   de          : display enable (inside the visible area)
//   px_x, px_y  : pixel coordinates while de, 0 otherwise
//   line_start  : pix_en cycle of pixel 0 of every line
//   frame_start : pix_en cycle of pixel (0,0)
// All outputs are registered from next-state values, so they describe the
// counters held in the same cycle and stay constant across a pixel slot.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic             sclk,
    input  logic             srst,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             line_start,
    output logic             frame_start
);

    if (DIV < 1 || DIV > 8) begin : g_div_chk
        $error("vga_sync_gen: DIV=%0d outside 1..8", DIV);
    end

    localparam int               DIV_W    = cnt_w(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en_d;
    logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_wrap, v_wrap;
    phase_t           h_phase, v_phase;
    logic             de_nxt;

    // pix_en is registered from the current divider count, so the first
    // pulse appears DIV edges after reset release (every cycle when DIV=1).
    assign pix_en_d = (div_cnt == DIV_LAST);

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= pix_en_d ? '0 : div_cnt + 1'b1;
            pix_en  <= pix_en_d;
        end
    end

    vga_axis_cnt #(
        .CNT_W (CNT_W),
        .ACT   (H_ACTIVE),
        .FP    (H_FP),
        .SYN   (H_SYNC),
        .BP    (H_BP),
        .POL   (SYNC_POL)
    ) u_h (
        .clk     (sclk),
        .rst_n   (srst),
        .en      (pix_en),
        .cnt     (h_cnt),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap),
        .phase   (h_phase),
        .sync    (hsync)
    );

    vga_axis_cnt #(
        .CNT_W (CNT_W),
        .ACT   (V_ACTIVE),
        .FP    (V_FP),
        .SYN   (V_SYNC),
        .BP    (V_BP),
        .POL   (SYNC_POL)
    ) u_v (
        .clk     (sclk),
        .rst_n   (srst),
        .en      (pix_en & h_wrap),
        .cnt     (v_cnt),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap),
        .phase   (v_phase),
        .sync    (vsync)
    );

    assign de_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= de_nxt;
            px_x        <= de_nxt ? h_nxt : '0;
            px_y        <= de_nxt ? v_nxt : '0;
            line_start  <= pix_en_d && (h_nxt == '0);
            frame_start <= pix_en_d && (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // Counters, phases and the vertical wrap are exposed by the axis blocks
    // but only the next-state counts and syncs are needed here.
    logic unused_ok;
    assign unused_ok = ^{h_cnt, v_cnt, v_wrap, h_phase, v_phase};

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances with a reduced raster (DIV=2 active-low
// sync, DIV=1 active-high sync) compared every cycle against an arithmetic
// model of slot index -> (h, v) -> outputs, plus period/width measurements and
// randomly timed asynchronous resets.
module tb_vga_sync_gen;

    localparam int HA = 20, HFP = 3, HS = 5, HB = 4, HT = HA + HFP + HS + HB;
    localparam int VA = 10, VFP = 2, VS = 2, VB = 3, VT = VA + VFP + VS + VB;
    localparam int CW = 11;
    localparam int DIV_A = 2, DIV_B = 1;
    localparam int FRAME_A = HT * VT * DIV_A;

    logic sclk = 1'b1;
    logic srst;
    always #10 sclk = ~sclk;

    logic pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [CW-1:0] x_a, y_a, x_b, y_b;

    vga_sync_gen #(
        .DIV(DIV_A), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .CNT_W(CW)
    ) u_a (
        .sclk(sclk), .srst(srst), .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a),
        .de(de_a), .px_x(x_a), .px_y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .DIV(DIV_B), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .CNT_W(CW)
    ) u_b (
        .sclk(sclk), .srst(srst), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b),
        .de(de_b), .px_x(x_b), .px_y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic          pe, hs, vs, de;
        logic [CW-1:0] x, y;
        logic          ls, fs;
    } obs_t;

    int n_chk = 0, n_err = 0;
    int k;          // sclk edges since reset release
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Edge kk after release lies in pixel slot (kk-1)/div; the slot index maps
    // straight onto raster position by division.
    function automatic obs_t model(input int kk, input int div, input bit pol);
        obs_t o;
        int s, h, v;
        o = '0;
        if (kk == 0) begin
            o.hs = ~pol;
            o.vs = ~pol;
            return o;
        end
        s    = (kk - 1) / div;
        h    = s % HT;
        v    = (s / HT) % VT;
        o.pe = ((kk - 1) % div) == div - 1;
        o.de = (h < HA) && (v < VA);
        o.x  = o.de ? CW'(h) : '0;
        o.y  = o.de ? CW'(v) : '0;
        o.hs = (h >= HA + HFP && h < HA + HFP + HS) ? pol : ~pol;
        o.vs = (v >= VA + VFP && v < VA + VFP + VS) ? pol : ~pol;
        o.ls = o.pe && (h == 0);
        o.fs = o.ls && (v == 0);
        return o;
    endfunction

    task automatic check_all();
        obs_t oa, ob;
        oa = {pe_a, hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a};
        ob = {pe_b, hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b};
        chk("a_out", {4'b0, oa}, {4'b0, model(k, DIV_A, 1'b0)});
        chk("b_out", {4'b0, ob}, {4'b0, model(k, DIV_B, 1'b1)});
    endtask

    // Measurement state for the undisturbed free run.
    int  last_fs = -1, de_pe = 0, n_fs = 0;
    int  hs_run = 0, last_hs = -1, vs_run = 0;
    int  hsb_run = 0, last_hsb = -1, b_pe_zero = 0;
    logic hs_a_q = 1'b1, hs_b_q = 1'b0;

    task automatic mon();
        if (fs_a) begin
            n_fs++;
            if (last_fs >= 0) begin
                chk("a_fs_gap", k - last_fs, FRAME_A);
                chk("a_de_pix", de_pe, HA * VA);
            end
            last_fs = k;
            de_pe   = 0;
        end
        if (de_a && pe_a) de_pe++;

        if (!hs_a) begin
            if (hs_a_q) begin
                if (last_hs >= 0) chk("a_hs_period", k - last_hs, HT * DIV_A);
                last_hs = k;
            end
            hs_run++;
        end else if (hs_run > 0) begin
            chk("a_hs_width", hs_run, HS * DIV_A);
            hs_run = 0;
        end
        hs_a_q = hs_a;

        if (!vs_a) vs_run++;
        else if (vs_run > 0) begin
            chk("a_vs_width", vs_run, VS * HT * DIV_A);
            vs_run = 0;
        end

        if (hs_b) begin
            if (!hs_b_q) begin
                if (last_hsb >= 0) chk("b_hs_period", k - last_hsb, HT * DIV_B);
                last_hsb = k;
            end
            hsb_run++;
        end else if (hsb_run > 0) begin
            chk("b_hs_width", hsb_run, HS * DIV_B);
            hsb_run = 0;
        end
        hs_b_q = hs_b;

        if (!pe_b) b_pe_zero++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge sclk);
            k++;
            @(negedge sclk);
            check_all();
            if (mon_en) mon();
        end
    endtask

    // Assert reset a few ns after an edge, check outputs at once, hold, release.
    task automatic rst_pulse(input int off);
        @(posedge sclk);
        #(off) srst = 1'b0;
        k = 0;
        #1 check_all();
        repeat ($urandom_range(1, 3)) begin
            @(negedge sclk);
            check_all();
        end
        @(negedge sclk);
        srst = 1'b1;
    endtask

    initial begin
        bit found;
        srst = 1'b0;
        k    = 0;
        #25 check_all();
        #5 srst = 1'b1;

        // Undisturbed run over two full frames with measurements.
        mon_en = 1'b1;
        run(2 * FRAME_A + 40);
        mon_en = 1'b0;
        chk("a_fs_count", n_fs, 3);
        chk("b_pe_low", b_pe_zero, 0);

        // Reset in the middle of the vsync pulse.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_A && !found; i++) begin
            run(1);
            if (model(k, DIV_A, 1'b0).vs == 1'b0) found = 1'b1;
        end
        chk("vs_reached", found, 1'b1);
        chk("a_vs_active", vs_a, 1'b0);
        rst_pulse($urandom_range(1, 8));
        run(FRAME_A / 2);

        // Randomly timed resets across the raster.
        for (int ep = 0; ep < 6; ep++) begin
            run($urandom_range(1, 1500));
            rst_pulse($urandom_range(1, 8));
        end
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
